rf_write_arbiter: RTL

- Shares the single register-file write port among N requesters: FSM sequencers that walk register numbers, load/store units and similar.
- Arbitrates round-robin and grants whole bursts.
- Muxes the granted requester's register number and data onto the write port.
- Sits between the sequencer FSMs and the register file. The register file sees one writer.

---
 rtl/rf_write_arbiter_pkg.sv | 30 +++
 rtl/en_dff.sv | 28 ++
 rtl/rf_write_arbiter_rr_pick.sv | 38 +++
 rtl/rf_write_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_write_arbiter_pkg
// Brief   : Shared constants and types for the register-file write arbiter.
// Revision: 1.0  initial release
// ============================================================================
package rf_write_arbiter_pkg;

  // Register numbers are 5 bits wide (32 architectural registers).
  localparam int RN_W = 5;

  // Register 0 is hard-wired; writes to it may be swallowed.
  localparam logic [RN_W-1:0] REG_ZERO = 5'd0;

  // Burst counter width; wide enough for MAX_BURST up to 255.
  localparam int CNT_W = 8;

  // Arbiter state encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/en_dff.sv
`default_nettype none
// ============================================================================
// Module  : en_dff
// Brief   : Enabled D flip-flop with synchronous active-low reset.
// Revision: 1.0  initial release
// ============================================================================
module en_dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; reset wins over enable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker. Returns the first requester at
//           or above rr_ptr (wrapping to 0) as a one-hot vector.
// Revision: 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [N_REQ-1:0] mask_hi;
  logic [N_REQ-1:0] req_hi;

  // Split requests into those at/above the pointer and isolate the lowest
  // set bit of the preferred group (x & -x); fall back to the full vector
  // when nothing is at or above the pointer, which gives the wrap-around.
  always_comb begin
    mask_hi = ~((ONE << rr_ptr) - ONE);
    req_hi  = req & mask_hi;
    if (req_hi != '0) begin
      winner = req_hi & (~req_hi + ONE);
    end else begin
      winner = req & (~req + ONE);
    end
    valid = (req != '0);
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_write_arbiter
// Brief   : Round-robin burst arbiter sharing one register-file write port
//           among N_REQ requesters; muxes the winner's regnum/data.
// Revision: 1.0  initial release
// ============================================================================
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int SKIP_ZERO = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [RN_W*N_REQ-1:0]   regnum,
  input  logic [DATA_W*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rf_wr_en,
  output logic [RN_W-1:0]         rf_wr_num,
  output logic [DATA_W-1:0]       rf_wr_data,
  output logic                    busy
);

  localparam int PTR_W = ptr_width(N_REQ);

  // Registered state
  logic [0:0]       state_bits_q;
  state_t           state_q;
  state_t           state_d;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] gnt_d;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;
  logic             rr_ptr_en;
  logic             burst_cnt_en;

  // Picker results
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_valid;

  // Granted-requester view
  logic [RN_W-1:0]   num_slice  [N_REQ];
  logic [DATA_W-1:0] data_slice [N_REQ];
  logic [PTR_W-1:0]  gnt_idx;
  logic              sel_req;
  logic              sel_last;
  logic [RN_W-1:0]   sel_num;
  logic [DATA_W-1:0] sel_data;

  logic accept;
  logic release_now;

  assign state_q = state_t'(state_bits_q);

  // Unpack the per-requester register number and data lanes.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign num_slice[i]  = regnum[RN_W*i +: RN_W];
    assign data_slice[i] = wdata[DATA_W*i +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  // Select the granted requester's controls and lanes; zero when idle.
  always_comb begin
    gnt_idx  = '0;
    sel_num  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        gnt_idx  = gnt_idx | PTR_W'(i);
        sel_num  = sel_num | num_slice[i];
        sel_data = sel_data | data_slice[i];
      end
    end
    sel_req  = |(req & gnt_q);
    sel_last = |(last & gnt_q);
  end

  // A write is taken only while granted with req held, never during reset.
  assign accept = (state_q == ST_GRANT) && sel_req && reset;

  // Next-state: arbitrate in IDLE, count and release bursts in GRANT.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    release_now  = 1'b0;
    burst_cnt_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_GRANT;
          gnt_d        = pick_onehot;
          burst_cnt_d  = '0;
          burst_cnt_en = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!sel_req) begin
          // Requester abandoned the burst.
          release_now = 1'b1;
        end else begin
          burst_cnt_d  = burst_cnt_q + CNT_W'(1);
          burst_cnt_en = 1'b1;
          if (sel_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            release_now = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    // Release always passes through IDLE, which yields the bubble cycle.
    if (release_now) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      if (gnt_idx == PTR_W'(N_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + PTR_W'(1);
      end
    end
    rr_ptr_en = release_now;
  end

  en_dff #(.W(1), .RST_VAL(1'b0)) u_state_ff (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .d     (state_d),
    .q     (state_bits_q)
  );

  en_dff #(.W(N_REQ), .RST_VAL('0)) u_gnt_ff (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .d     (gnt_d),
    .q     (gnt_q)
  );

  en_dff #(.W(PTR_W), .RST_VAL('0)) u_rr_ptr_ff (
    .clock (clock),
    .reset (reset),
    .en    (rr_ptr_en),
    .d     (rr_ptr_d),
    .q     (rr_ptr_q)
  );

  en_dff #(.W(CNT_W), .RST_VAL('0)) u_burst_cnt_ff (
    .clock (clock),
    .reset (reset),
    .en    (burst_cnt_en),
    .d     (burst_cnt_d),
    .q     (burst_cnt_q)
  );

  // Write port is driven only on an accepted write, otherwise held at zero.
  assign rf_wr_en   = accept && !((SKIP_ZERO != 0) && (sel_num == REG_ZERO));
  assign rf_wr_num  = accept ? sel_num  : '0;
  assign rf_wr_data = accept ? sel_data : '0;
  assign gnt        = gnt_q;
  assign busy       = (state_q == ST_GRANT);

endmodule
`default_nettype wire
